// File: rtl/bank_rotator.sv
// bank_rotator: assigns source / destination / display roles to NUM_BANKS
// external row BRAMs, sequences generations of the cellular-automaton engine
// and moves display changes onto frame boundaries so video never tears.
module bank_rotator #(
    parameter int NUM_BANKS = 2,
    parameter int X_SIZE    = 1280,
    parameter int Y_SIZE    = 720,
    parameter int Y_WIDTH   = 10
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           pause,
    input  logic                           step,
    input  logic                           frame_start,
    output logic                           gen_start,
    input  logic [Y_WIDTH-1:0]             fetch_addr,
    output logic [X_SIZE-1:0]              fetch_data,
    input  logic [Y_WIDTH-1:0]             wr_addr,
    input  logic [X_SIZE-1:0]              wr_data,
    input  logic                           wr_en,
    input  logic [Y_WIDTH-1:0]             vid_addr,
    output logic [X_SIZE-1:0]              vid_data,
    output logic [NUM_BANKS*Y_WIDTH-1:0]   bank_addra,
    output logic [NUM_BANKS*Y_WIDTH-1:0]   bank_addrb,
    output logic [NUM_BANKS*X_SIZE-1:0]    bank_dina,
    output logic [NUM_BANKS-1:0]           bank_wea,
    input  logic [NUM_BANKS*X_SIZE-1:0]    bank_douta,
    input  logic [NUM_BANKS*X_SIZE-1:0]    bank_doutb,
    output logic [1:0]                     src_bank,
    output logic [1:0]                     dst_bank,
    output logic [1:0]                     disp_bank,
    output logic [15:0]                    gen_count,
    output logic                           busy
);

    // Only ping-pong and triple buffering have defined role rotations.
    if (NUM_BANKS != 2 && NUM_BANKS != 3) begin : g_bad_num_banks
        $error("bank_rotator: NUM_BANKS must be 2 or 3");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_COMPUTE,
        S_WAIT_FRAME,
        S_SWAP
    } state_t;

    // One extra bit so a row count equal to Y_SIZE is representable.
    localparam logic [Y_WIDTH:0] ROW_LIMIT = (Y_WIDTH+1)'(Y_SIZE);
    localparam logic [Y_WIDTH:0] LAST_ROW  = (Y_WIDTH+1)'(Y_SIZE - 1);
    localparam logic [Y_WIDTH:0] ROW_ONE   = (Y_WIDTH+1)'(1);

    state_t             state_q, state_d;
    logic [Y_WIDTH:0]   row_cnt_q;
    logic [1:0]         src_q, dst_q, disp_q;
    logic [1:0]         src_d, dst_d, disp_d;
    logic [1:0]         new_src, swap_dst;
    logic [1:0]         src_rd_q, disp_rd_q;
    logic [15:0]        gen_count_q;
    logic               wr_accept;
    logic               last_row;

    // Only in-range rows written during COMPUTE reach the destination bank.
    assign wr_accept = (state_q == S_COMPUTE) && wr_en && ({1'b0, wr_addr} < ROW_LIMIT);
    assign last_row  = wr_accept && (row_cnt_q == LAST_ROW);

    assign gen_start = (state_q == S_START);
    assign busy      = (state_q != S_IDLE);
    assign src_bank  = src_q;
    assign dst_bank  = dst_q;
    assign disp_bank = disp_q;
    assign gen_count = gen_count_q;

    // Generation FSM next-state logic.
    always_comb begin
        // NOTE: every branch starts from a default so no latch is inferred.
        state_d = state_q;
        case (state_q)
            S_IDLE:       if (!pause || step) state_d = S_START;
            S_START:      state_d = S_COMPUTE;
            S_COMPUTE:    if (last_row) state_d = (NUM_BANKS == 3) ? S_SWAP : S_WAIT_FRAME;
            S_WAIT_FRAME: if (frame_start) state_d = S_SWAP;
            S_SWAP:       state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    // Role rotation at SWAP and frame-aligned display updates.
    always_comb begin
        new_src = dst_q;
        if (NUM_BANKS == 2) begin
            swap_dst = src_q;
        end else if (new_src == disp_q) begin
            swap_dst = (new_src == 2'd2) ? 2'd0 : new_src + 2'd1;
        end else begin
            // The three indices sum to 3, so the remaining bank is 3 - a - b.
            swap_dst = 2'd3 - new_src - disp_q;
        end

        src_d  = src_q;
        dst_d  = dst_q;
        disp_d = disp_q;
        if (state_q == S_SWAP) begin
            src_d = new_src;
            dst_d = swap_dst;
        end
        // src_d already holds the new source when SWAP and frame_start coincide.
        if (NUM_BANKS == 2) begin
            disp_d = src_d;
        end else if (frame_start) begin
            disp_d = src_d;
        end
    end

    // State, row counter, roles, generation counter and read-select delays.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            row_cnt_q   <= '0;
            src_q       <= 2'd0;
            dst_q       <= 2'd1;
            disp_q      <= 2'd0;
            gen_count_q <= '0;
            src_rd_q    <= 2'd0;
            disp_rd_q   <= 2'd0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            disp_q    <= disp_d;
            src_rd_q  <= src_q;
            disp_rd_q <= disp_q;
            if (state_q == S_START) begin
                row_cnt_q <= '0;
            end else if (wr_accept) begin
                row_cnt_q <= row_cnt_q + ROW_ONE;
            end
            if (state_q == S_SWAP) begin
                gen_count_q <= gen_count_q + 16'd1;
            end
        end
    end

    // Per-bank port steering: dst takes the write port, all others are read.
    always_comb begin
        bank_addra = '0;
        bank_addrb = '0;
        bank_dina  = '0;
        bank_wea   = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            bank_addrb[i*Y_WIDTH +: Y_WIDTH] = vid_addr;
            bank_dina[i*X_SIZE +: X_SIZE]    = wr_data;
            if (dst_q == 2'(i)) begin
                bank_addra[i*Y_WIDTH +: Y_WIDTH] = wr_addr;
                bank_wea[i]                      = wr_accept;
            end else begin
                bank_addra[i*Y_WIDTH +: Y_WIDTH] = fetch_addr;
            end
        end
    end

    // Read muxes use the roles of the previous cycle to match BRAM latency.
    always_comb begin
        fetch_data = '0;
        vid_data   = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (src_rd_q == 2'(i)) fetch_data = bank_douta[i*X_SIZE +: X_SIZE];
            if (disp_rd_q == 2'(i)) vid_data  = bank_doutb[i*X_SIZE +: X_SIZE];
        end
    end

endmodule

// File: tb/tb_bank_rotator.sv
// Self-checking bench for bank_rotator: one ping-pong (k=0) and one triple
// buffer (k=1) instance, each with its own behavioural BRAM set.
module tb_bank_rotator;

    localparam int X  = 16;
    localparam int YS = 4;
    localparam int YW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic          pause_s [2];
    logic          step_s [2];
    logic          frame_s [2];
    logic          wr_en_s [2];
    logic [YW-1:0] wr_addr_s [2];
    logic [YW-1:0] fetch_addr_s [2];
    logic [YW-1:0] vid_addr_s [2];
    logic [X-1:0]  wr_data_s [2];

    wire          gen_start_s [2];
    wire          busy_s [2];
    wire [1:0]    src_s [2];
    wire [1:0]    dst_s [2];
    wire [1:0]    disp_s [2];
    wire [15:0]   gen_s [2];
    wire [X-1:0]  fetch_data_s [2];
    wire [X-1:0]  vid_data_s [2];
    wire [2:0]    wea_s [2];
    wire [7:0]    wcnt_s [2][3];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int gcnt [2] = '{0, 0};

    typedef struct {
        int           k;
        bit           vid;
        logic [X-1:0] exp;
        int           due;
    } rd_t;
    rd_t sb [$];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int NB = k + 2;
        logic [NB*YW-1:0] addra, addrb;
        logic [NB*X-1:0]  dina, douta, doutb;
        logic [NB-1:0]    wea;
        logic             gen_start, busy;
        logic [1:0]       src, dst, disp;
        logic [15:0]      gen_count;
        logic [X-1:0]     fetch_data, vid_data;
        logic [X-1:0]     mem [NB][8];
        logic [7:0]       wcnt [3];

        bank_rotator #(.NUM_BANKS(NB), .X_SIZE(X), .Y_SIZE(YS), .Y_WIDTH(YW)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .pause       (pause_s[k]),
            .step        (step_s[k]),
            .frame_start (frame_s[k]),
            .gen_start   (gen_start),
            .fetch_addr  (fetch_addr_s[k]),
            .fetch_data  (fetch_data),
            .wr_addr     (wr_addr_s[k]),
            .wr_data     (wr_data_s[k]),
            .wr_en       (wr_en_s[k]),
            .vid_addr    (vid_addr_s[k]),
            .vid_data    (vid_data),
            .bank_addra  (addra),
            .bank_addrb  (addrb),
            .bank_dina   (dina),
            .bank_wea    (wea),
            .bank_douta  (douta),
            .bank_doutb  (doutb),
            .src_bank    (src),
            .dst_bank    (dst),
            .disp_bank   (disp),
            .gen_count   (gen_count),
            .busy        (busy)
        );

        // Behavioural dual-port BRAMs, read-first, one cycle latency.
        always @(posedge clk) begin
            for (int b = 0; b < NB; b++) begin
                if (wea[b]) mem[b][addra[b*YW +: YW]] <= dina[b*X +: X];
                douta[b*X +: X] <= mem[b][addra[b*YW +: YW]];
                doutb[b*X +: X] <= mem[b][addrb[b*YW +: YW]];
            end
        end

        // Count accepted writes per bank.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int b = 0; b < 3; b++) wcnt[b] <= 8'd0;
            end else begin
                for (int b = 0; b < NB; b++) if (wea[b]) wcnt[b] <= wcnt[b] + 8'd1;
            end
        end

        assign gen_start_s[k]  = gen_start;
        assign busy_s[k]       = busy;
        assign src_s[k]        = src;
        assign dst_s[k]        = dst;
        assign disp_s[k]       = disp;
        assign gen_s[k]        = gen_count;
        assign fetch_data_s[k] = fetch_data;
        assign vid_data_s[k]   = vid_data;
        assign wea_s[k]        = 3'(wea);
        for (genvar b = 0; b < 3; b++) begin : g_wc
            assign wcnt_s[k][b] = wcnt[b];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard drain, role invariant and gen_start pulse counting.
    always @(negedge clk) begin
        rd_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.vid) check("vid_data", vid_data_s[e.k], e.exp);
            else       check("fetch_data", fetch_data_s[e.k], e.exp);
        end
        for (int k = 0; k < 2; k++) begin
            check("inv_dst_ne_src", 32'(dst_s[k] != src_s[k]), 1);
            check("inv_dst_ne_disp", 32'(dst_s[k] != disp_s[k]), 1);
            if (gen_start_s[k]) gcnt[k] = gcnt[k] + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic roles(input int k, input string tag, input logic [1:0] s,
                         input logic [1:0] d, input logic [1:0] p, input logic [15:0] g);
        check({tag, "_src"}, src_s[k], s);
        check({tag, "_dst"}, dst_s[k], d);
        check({tag, "_disp"}, disp_s[k], p);
        check({tag, "_gen"}, gen_s[k], g);
    endtask

    // Waits (bounded) for gen_start, then returns in the first COMPUTE cycle.
    task automatic wait_gen(input int k, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (gen_start_s[k]) seen = 1'b1;
        end
        check({tag, "_gen_start"}, 32'(seen), 1);
        check({tag, "_busy"}, busy_s[k], 1);
        tick();
    endtask

    task automatic wr_cycle(input int k, input logic [YW-1:0] a, input logic [X-1:0] d,
                            input logic [2:0] exp_wea, input string tag);
        wr_en_s[k]   = 1'b1;
        wr_addr_s[k] = a;
        wr_data_s[k] = d;
        @(negedge clk);
        check(tag, wea_s[k], exp_wea);
        tick();
        wr_en_s[k] = 1'b0;
    endtask

    task automatic read_row(input int k, input logic [YW-1:0] r,
                            input logic [X-1:0] exp_vid, input logic [X-1:0] exp_fetch);
        vid_addr_s[k]   = r;
        fetch_addr_s[k] = r;
        sb.push_back('{k: k, vid: 1'b1, exp: exp_vid, due: cyc + 1});
        sb.push_back('{k: k, vid: 1'b0, exp: exp_fetch, due: cyc + 1});
        tick();
    endtask

    task automatic step_pulse(input int k);
        step_s[k] = 1'b1;
        tick();
        step_s[k] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            pause_s[k] = 1'b1; step_s[k] = 1'b0; frame_s[k] = 1'b0; wr_en_s[k] = 1'b0;
            wr_addr_s[k] = '0; fetch_addr_s[k] = '0; vid_addr_s[k] = '0; wr_data_s[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            roles(k, "rst", 2'd0, 2'd1, 2'd0, 16'd0);
            check("rst_busy", busy_s[k], 0);
            check("rst_wea", wea_s[k], 0);
        end
        tick();
        rst_n = 1'b1;
        tick();

        // ---------------- ping-pong instance ----------------
        wr_cycle(0, 3'd0, 16'hFFFF, 3'b000, "pp_idle_wea");
        pause_s[0] = 1'b0;
        tick();
        pause_s[0] = 1'b1;
        wait_gen(0, "pp");
        for (int r = 0; r < YS; r++) begin
            if (r == YS - 1) frame_s[0] = 1'b1;
            wr_cycle(0, YW'(r), 16'hA500 + X'(r), 3'b010, "pp_wea");
            frame_s[0] = 1'b0;
        end
        repeat (10) tick();
        @(negedge clk);
        roles(0, "pp_wait", 2'd0, 2'd1, 2'd0, 16'd0);
        check("pp_wait_busy", busy_s[0], 1);
        check("pp_bank0_writes", wcnt_s[0][0], 0);
        check("pp_bank1_writes", wcnt_s[0][1], 4);
        tick();
        frame_s[0] = 1'b1;
        tick();
        frame_s[0] = 1'b0;
        @(negedge clk);
        check("pp_swap_src_hold", src_s[0], 0);
        check("pp_swap_busy", busy_s[0], 1);
        tick();
        @(negedge clk);
        roles(0, "pp_after", 2'd1, 2'd0, 2'd1, 16'd1);
        check("pp_idle_busy", busy_s[0], 0);
        tick();
        for (int r = 0; r < YS; r++) read_row(0, YW'(r), 16'hA500 + X'(r), 16'hA500 + X'(r));
        repeat (2) tick();

        // ---------------- triple-buffer instance ----------------
        wr_cycle(1, 3'd0, 16'hFFFF, 3'b000, "tb_idle_wea");
        g0 = gcnt[1];
        repeat (50) tick();
        check("paused_no_gen", 32'(gcnt[1] - g0), 0);

        g0 = gcnt[1];
        step_pulse(1);
        wait_gen(1, "step1");
        step_s[1] = 1'b1;
        wr_cycle(1, 3'd0, 16'hA500, 3'b010, "tb_wea");
        step_s[1] = 1'b0;
        wr_cycle(1, 3'd1, 16'hA501, 3'b010, "tb_wea");
        wr_cycle(1, 3'd4, 16'hDEAD, 3'b000, "tb_oob_wea");
        wr_cycle(1, 3'd2, 16'hA502, 3'b010, "tb_wea");
        @(negedge clk);
        check("oob_not_counted_busy", busy_s[1], 1);
        check("oob_not_counted_src", src_s[1], 0);
        tick();
        wr_cycle(1, 3'd3, 16'hA503, 3'b010, "tb_wea");
        @(negedge clk);
        check("tb_swap_gen_hold", gen_s[1], 0);
        tick();
        @(negedge clk);
        roles(1, "tb_gen1", 2'd1, 2'd2, 2'd0, 16'd1);
        tick();
        repeat (10) tick();
        check("one_gen_per_step", 32'(gcnt[1] - g0), 1);
        check("step_idle_busy", busy_s[1], 0);

        frame_s[1] = 1'b1;
        tick();
        frame_s[1] = 1'b0;
        @(negedge clk);
        roles(1, "tb_frame", 2'd1, 2'd2, 2'd1, 16'd1);
        tick();
        for (int r = 0; r < YS; r++) read_row(1, YW'(r), 16'hA500 + X'(r), 16'hA500 + X'(r));

        step_pulse(1);
        wait_gen(1, "gen2");
        for (int r = 0; r < YS; r++) wr_cycle(1, YW'(r), 16'h5A00 + X'(r), 3'b100, "gen2_wea");
        tick();
        @(negedge clk);
        roles(1, "tb_gen2", 2'd2, 2'd0, 2'd1, 16'd2);
        tick();
        for (int r = 0; r < YS; r++) read_row(1, YW'(r), 16'hA500 + X'(r), 16'h5A00 + X'(r));

        // Reset in the middle of a generation.
        step_pulse(1);
        wait_gen(1, "gen3");
        wr_cycle(1, 3'd0, 16'h1111, 3'b001, "gen3_wea");
        wr_cycle(1, 3'd1, 16'h1112, 3'b001, "gen3_wea");
        rst_n = 1'b0;
        @(negedge clk);
        roles(1, "midrst", 2'd0, 2'd1, 2'd0, 16'd0);
        check("midrst_busy", busy_s[1], 0);
        check("midrst_wea", wea_s[1], 0);
        check("midrst_gen_start", gen_start_s[1], 0);
        tick();
        rst_n = 1'b1;
        tick();

        // frame_start arriving in the SWAP cycle.
        step_pulse(1);
        wait_gen(1, "sim");
        for (int r = 0; r < YS; r++) wr_cycle(1, YW'(r), 16'h3C00 + X'(r), 3'b010, "sim_wea");
        frame_s[1] = 1'b1;
        tick();
        frame_s[1] = 1'b0;
        @(negedge clk);
        roles(1, "sim_swap", 2'd1, 2'd2, 2'd1, 16'd1);
        tick();
        for (int r = 0; r < YS; r++) read_row(1, YW'(r), 16'h3C00 + X'(r), 16'h3C00 + X'(r));
        repeat (3) tick();
        check("sb_drained", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
